// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Purpose:
//   Shares one single-ported unified memory between the CPU instruction-fetch
//   (I) port and data (D) port, one transaction at a time. D has priority. A
//   starvation counter forces I to win once it has lost STARVE_LIMIT
//   arbitrations in a row while requesting.
//
// Handshake:
//   Requesters raise a level (imem_read_en, dmem_read_en/dmem_write_en) and hold
//   it, with address/data stable, until their *_ready pulses for one cycle.
//   They drop the level in the cycle after *_ready. Downstream, mem_req is held
//   high with mem_addr/mem_wdata/mem_we stable until mem_ack is seen. mem_ack
//   may arrive in the first cycle of mem_req.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_addr/read_en                 fetch request
//   imem_read_data/ready              fetch result and one-cycle completion pulse
//   dmem_addr/write_data/read_en/write_en   load/store request (store wins)
//   dmem_read_data/ready              load result and one-cycle completion pulse
//   mem_addr/wdata/we/req             registered downstream request
//   mem_rdata/ack                     downstream response
//   arb_busy                          high whenever the FSM is not IDLE
//   bus_err                           watchdog-abort pulse (with *_ready)
//   state_dbg                         current FSM state (0 IDLE, 1 BUSY, 2 RESP)
//
// Optional feature:
//   ARB_TIMEOUT_EN - when defined, a BUSY watchdog aborts a transfer after
//   TIMEOUT_CYCLES cycles without mem_ack, returns 32'hDEADBEEF to a reader and
//   pulses bus_err. When undefined, BUSY waits forever and bus_err is 0.
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_read_en,
    output logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  imem_ready,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_write_data,
    input  logic                  dmem_read_en,
    input  logic                  dmem_write_en,
    output logic [DATA_WIDTH-1:0] dmem_read_data,
    output logic                  dmem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  arb_busy,
    output logic                  bus_err,
    output logic [1:0]            state_dbg
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("unified_mem_arbiter: STARVE_LIMIT must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("unified_mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    logic       owner_d;     // 1: D owns the current transfer, 0: I owns it
    logic [3:0] starve_cnt;  // consecutive arbitrations I lost while requesting

    logic i_req;
    logic d_req;
    logic i_wins;

    assign i_req  = imem_read_en;
    assign d_req  = dmem_read_en | dmem_write_en;
    // D wins by default; I wins when D is quiet or I has been starved long enough.
    assign i_wins = i_req && (!d_req || (starve_cnt == STARVE_MAX));

    assign arb_busy  = (state != ST_IDLE);
    assign state_dbg = state;

`ifdef ARB_TIMEOUT_EN
    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;       // BUSY cycles seen so far without mem_ack
    logic          bus_err_q;

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            owner_d        <= 1'b0;
            starve_cnt     <= 4'd0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            imem_ready     <= 1'b0;
            dmem_ready     <= 1'b0;
            imem_read_data <= '0;
            dmem_read_data <= '0;
`ifdef ARB_TIMEOUT_EN
            timer          <= '0;
            bus_err_q      <= 1'b0;
`endif
        end else begin
            // Completion pulses last exactly one cycle (the RESP cycle).
            imem_ready <= 1'b0;
            dmem_ready <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus_err_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        state   <= ST_BUSY;
                        mem_req <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        timer   <= '0;
`endif
                        if (i_wins) begin
                            owner_d    <= 1'b0;
                            mem_addr   <= imem_addr;
                            mem_we     <= 1'b0;
                            starve_cnt <= 4'd0;
                        end else begin
                            owner_d   <= 1'b1;
                            mem_addr  <= dmem_addr;
                            mem_wdata <= dmem_write_data;
                            mem_we    <= dmem_write_en;
                            // Count a loss only when I was actually waiting.
                            if (i_req && (starve_cnt != STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                    end
                end

                ST_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_RESP;
                        if (owner_d) begin
                            dmem_ready <= 1'b1;
                            if (!mem_we) begin
                                dmem_read_data <= mem_rdata;
                            end
                        end else begin
                            imem_ready     <= 1'b1;
                            imem_read_data <= mem_rdata;
                        end
`ifdef ARB_TIMEOUT_EN
                    end else if (timer == TIMER_LAST) begin
                        // Watchdog abort: complete the request with an error marker.
                        mem_req   <= 1'b0;
                        state     <= ST_RESP;
                        bus_err_q <= 1'b1;
                        if (owner_d) begin
                            dmem_ready <= 1'b1;
                            if (!mem_we) begin
                                dmem_read_data <= DATA_WIDTH'(32'hDEADBEEF);
                            end
                        end else begin
                            imem_ready     <= 1'b1;
                            imem_read_data <= DATA_WIDTH'(32'hDEADBEEF);
                        end
                    end else begin
                        timer <= timer + TW'(1);
`endif
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
